// File: rtl/qpsk_tx_scheduler.sv
// qpsk_tx_scheduler
// Frame sequencer in front of the QPSK modulator. Each frame is a preamble
// (alternating 00/10), the 16-bit sync word as 8 MSB-first dibits, then
// frame_len payload bytes as 4 MSB-first dibits each. One symbol advances per
// mod_req pulse. This block is the sole driver of the modulator's fcw.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, abort       frame request (IDLE only) / terminate current frame
//   frame_len, cfg_fcw payload byte count and carrier FCW, sampled with start
//   tx_data/valid/ready  payload byte stream (one-byte buffer)
//   mod_req            modulator took the presented symbol
//   symbol_in/en       symbol presented to the modulator / symbol valid
//   fcw                modulator FCW
//   busy, done         not-IDLE / one-cycle end-of-frame pulse
//   underrun           sticky, set when a payload byte was not ready in time
//   state_dbg          current FSM state (0 IDLE, 1 PREAMBLE, 2 SYNC, 3 PAYLOAD)
module qpsk_tx_scheduler #(
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [15:0] SYNC_WORD    = 16'h1ACF,
  parameter logic [31:0] DEFAULT_FCW  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] frame_len,
  input  logic [31:0] cfg_fcw,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        mod_req,
  output logic [1:0]  symbol_in,
  output logic        symbol_en,
  output logic [31:0] fcw,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_PAYLOAD} state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;         // symbol index within the current state
  logic [15:0] sr, sr_nxt;           // dibits still to send, MSB-first
  logic [15:0] len_q, len_nxt;       // payload bytes in this frame
  logic [15:0] sent, sent_nxt;       // bytes moved into the shift register
  logic [15:0] fetched, fetched_nxt; // bytes accepted from the source
  logic        buf_v, buf_v_nxt;
  logic [7:0]  buf_d, buf_d_nxt;
  logic [1:0]  sym_nxt;
  logic        en_nxt, ready_nxt, done_nxt, ur_nxt;
  logic [31:0] fcw_nxt;

  logic start_ok, adv, accept;
  logic load_byte, finish, set_ur;

  // Byte handshake: a byte transfers on every rising edge where tx_valid and
  // tx_ready are both high; tx_valid may not depend on tx_ready, and tx_ready
  // is registered, so it is high only while the buffer is empty.
  assign accept   = tx_valid && tx_ready;
  assign start_ok = start && (state == S_IDLE);
  // abort wins over mod_req in the same cycle
  assign adv      = mod_req && !abort && (state != S_IDLE);
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and frame-boundary decisions
  always_comb begin
    state_nxt = state;
    load_byte = 1'b0;
    finish    = 1'b0;
    set_ur    = 1'b0;
    case (state)
      S_IDLE:     if (start_ok) state_nxt = S_PREAMBLE;
      S_PREAMBLE: if (adv && cnt == PRE_LAST) state_nxt = S_SYNC;
      S_SYNC: begin
        if (adv && cnt == 16'd7) begin
          if (len_q == 16'd0) finish = 1'b1;
          else if (buf_v) begin
            load_byte = 1'b1;
            state_nxt = S_PAYLOAD;
          end else begin
            set_ur = 1'b1;
            finish = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (adv && cnt == 16'd3) begin
          if (sent == len_q) finish = 1'b1;
          else if (buf_v) load_byte = 1'b1;
          else begin
            set_ur = 1'b1;
            finish = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (finish) state_nxt = S_IDLE;
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  // Next values of the datapath and the registered outputs
  always_comb begin
    cnt_nxt     = cnt;
    sr_nxt      = sr;
    len_nxt     = len_q;
    sent_nxt    = sent;
    fetched_nxt = fetched;
    buf_d_nxt   = buf_d;
    sym_nxt     = symbol_in;
    en_nxt      = symbol_en;
    done_nxt    = 1'b0;
    ur_nxt      = underrun;
    fcw_nxt     = fcw;
    if (accept) begin
      buf_d_nxt   = tx_data;
      fetched_nxt = fetched + 16'd1;
    end
    // A drain on the same edge as a fill takes the old contents; the new
    // byte stays in the buffer.
    buf_v_nxt = accept || (buf_v && !load_byte);

    if (start_ok) begin
      len_nxt     = frame_len;
      fcw_nxt     = cfg_fcw;
      ur_nxt      = 1'b0;
      cnt_nxt     = 16'd0;
      sent_nxt    = 16'd0;
      fetched_nxt = 16'd0;
      buf_v_nxt   = 1'b0;
      sym_nxt     = 2'b00;
      en_nxt      = 1'b1;
    end else if (abort && state != S_IDLE) begin
      buf_v_nxt = 1'b0;
      sym_nxt   = 2'b00;
      en_nxt    = 1'b0;
    end else if (adv) begin
      if (finish) begin
        buf_v_nxt = 1'b0;
        sym_nxt   = 2'b00;
        en_nxt    = 1'b0;
        done_nxt  = 1'b1;
        ur_nxt    = underrun || set_ur;
      end else if (load_byte) begin
        sym_nxt  = buf_d[7:6];
        sr_nxt   = {buf_d[5:0], 10'b0};
        cnt_nxt  = 16'd0;
        sent_nxt = sent + 16'd1;
      end else if (state == S_PREAMBLE) begin
        if (cnt == PRE_LAST) begin
          cnt_nxt = 16'd0;
          sym_nxt = SYNC_WORD[15:14];
          sr_nxt  = {SYNC_WORD[13:0], 2'b00};
        end else begin
          cnt_nxt = cnt + 16'd1;
          // next index is odd exactly when the current one is even
          sym_nxt = cnt[0] ? 2'b00 : 2'b10;
        end
      end else begin
        cnt_nxt = cnt + 16'd1;
        sym_nxt = sr[15:14];
        sr_nxt  = {sr[13:0], 2'b00};
      end
    end

    ready_nxt = ((state_nxt == S_SYNC) || (state_nxt == S_PAYLOAD)) &&
                !buf_v_nxt && (fetched_nxt < len_nxt);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 16'd0;
      sr        <= 16'd0;
      len_q     <= 16'd0;
      sent      <= 16'd0;
      fetched   <= 16'd0;
      buf_v     <= 1'b0;
      buf_d     <= 8'h00;
      symbol_in <= 2'b00;
      symbol_en <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      fcw       <= DEFAULT_FCW;
    end else begin
      cnt       <= cnt_nxt;
      sr        <= sr_nxt;
      len_q     <= len_nxt;
      sent      <= sent_nxt;
      fetched   <= fetched_nxt;
      buf_v     <= buf_v_nxt;
      buf_d     <= buf_d_nxt;
      symbol_in <= sym_nxt;
      symbol_en <= en_nxt;
      tx_ready  <= ready_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
      underrun  <= ur_nxt;
      fcw       <= fcw_nxt;
    end
  end

endmodule

// File: tb/tb_qpsk_tx_scheduler.sv
// Testbench for qpsk_tx_scheduler: scenario tasks drive frames and compare the
// symbol stream against a list built directly from the frame format.
module tb_qpsk_tx_scheduler;
  localparam int          PL   = 4;
  localparam logic [15:0] SW   = 16'h1ACF;
  localparam logic [31:0] DFCW = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] frame_len = 16'd0;
  logic [31:0] cfg_fcw = 32'd0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        mod_req = 1'b0;
  logic [1:0]  symbol_in;
  logic        symbol_en;
  logic [31:0] fcw;
  logic        busy, done, underrun;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];
  logic [7:0] src_q[$];
  logic       saw_ready;

  qpsk_tx_scheduler #(.PREAMBLE_LEN(PL), .SYNC_WORD(SW), .DEFAULT_FCW(DFCW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .frame_len(frame_len), .cfg_fcw(cfg_fcw), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .mod_req(mod_req),
    .symbol_in(symbol_in), .symbol_en(symbol_en), .fcw(fcw), .busy(busy),
    .done(done), .underrun(underrun), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: the whole frame's symbol list from the frame format.
  task automatic build_expected(input int len);
    int nb;
    exp_q.delete();
    for (int i = 0; i < PL; i++) exp_q.push_back((i % 2 == 1) ? 2'b10 : 2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back(2'(SW >> (14 - 2 * i)));
    nb = (src_q.size() < len) ? src_q.size() : len;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < 4; k++) exp_q.push_back(2'(src_q[b] >> (6 - 2 * k)));
  endtask

  // Runs one frame: bytes come from src_q, mod_req every 'period' cycles.
  // abort_at / restart_at / reset_at name the mod_req pulse (1-based) that
  // carries that extra event; 0 means none.
  task automatic run_frame(input int len, input int period, input int abort_at,
                           input int restart_at, input int reset_at,
                           input logic [31:0] cfgv);
    int   n_exp, pulses, cyc, phase, budget;
    logic exp_ur, ended;
    build_expected(len);
    n_exp  = exp_q.size();
    exp_ur = (src_q.size() < len);
    budget = (n_exp + 4) * period + 50;
    @(negedge clk);
    start = 1'b1; frame_len = 16'(len); cfg_fcw = cfgv;
    @(negedge clk);
    start = 1'b0; frame_len = 16'($urandom); cfg_fcw = $urandom;
    n_checks++;
    if ({busy, symbol_en, underrun, done} !== 4'b1100)
      $display("FAIL start_flags: got busy/en/ur/done=%b want 1100", {busy, symbol_en, underrun, done});
    else n_pass++;
    n_checks++;
    if (fcw !== cfgv) $display("FAIL start_fcw: got %h want %h", fcw, cfgv);
    else n_pass++;
    pulses = 0; cyc = 0; phase = 0; ended = 1'b0; saw_ready = 1'b0;
    while (!ended) begin
      mod_req = 1'b0; abort = 1'b0; start = 1'b0; reset = 1'b0;
      if (tx_ready) saw_ready = 1'b1;
      if (done) begin
        n_checks++;
        if (pulses != n_exp) $display("FAIL done_pulses: got %0d want %0d", pulses, n_exp);
        else n_pass++;
        n_checks++;
        if ({symbol_en, busy, underrun} !== {1'b0, 1'b0, exp_ur})
          $display("FAIL end_flags: got en/busy/ur=%b want %b", {symbol_en, busy, underrun}, {2'b00, exp_ur});
        else n_pass++;
        ended = 1'b1;
      end else if (cyc >= budget) begin
        n_checks++;
        $display("FAIL timeout: got %0d pulses want done after %0d", pulses, n_exp);
        ended = 1'b1;
      end else if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL done_missing: got done=0 want 1 after %0d pulses", pulses);
        ended = 1'b1;
      end else begin
        n_checks++;
        if ({symbol_en, symbol_in} !== {1'b1, exp_q[0]})
          $display("FAIL symbol[%0d]: got en=%b sym=%b want en=1 sym=%b", pulses, symbol_en, symbol_in, exp_q[0]);
        else n_pass++;
        if (phase == period - 1) begin
          void'(exp_q.pop_front());
          mod_req = 1'b1;
          pulses++;
          phase = 0;
          if (pulses == abort_at) abort = 1'b1;
          if (pulses == restart_at) begin
            start = 1'b1; frame_len = 16'(len + 3); cfg_fcw = ~cfgv;
          end
          if (pulses == reset_at) reset = 1'b1;
        end else phase++;
      end
      // source driver: offer the next byte; it transfers if tx_ready is high
      tx_valid = (src_q.size() > 0);
      tx_data  = tx_valid ? src_q[0] : 8'h00;
      if (tx_valid && tx_ready) void'(src_q.pop_front());
      if (!ended) begin
        @(negedge clk);
        cyc++;
        if (abort) begin
          n_checks++;
          if ({busy, symbol_en, tx_ready, done} !== 4'b0000)
            $display("FAIL abort: got busy/en/ready/done=%b want 0000", {busy, symbol_en, tx_ready, done});
          else n_pass++;
          ended = 1'b1;
        end
        if (reset) begin
          n_checks++;
          if ({symbol_in, symbol_en, tx_ready, busy, done, underrun} !== 7'b0)
            $display("FAIL reset_mid: got sym/en/ready/busy/done/ur=%b want 0", {symbol_in, symbol_en, tx_ready, busy, done, underrun});
          else n_pass++;
          n_checks++;
          if (fcw !== DFCW) $display("FAIL reset_fcw: got %h want %h", fcw, DFCW);
          else n_pass++;
          ended = 1'b1;
        end
        if (start) begin
          n_checks++;
          if ({busy, fcw} !== {1'b1, cfgv})
            $display("FAIL restart_ignored: got busy=%b fcw=%h want 1 %h", busy, fcw, cfgv);
          else n_pass++;
        end
      end
    end
    mod_req = 1'b0; abort = 1'b0; start = 1'b0; reset = 1'b0; tx_valid = 1'b0;
    src_q.delete();
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_width: got %b want 0", done);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({symbol_in, symbol_en, tx_ready, busy, done, underrun} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0", {symbol_in, symbol_en, tx_ready, busy, done, underrun});
    else n_pass++;
    n_checks++;
    if (fcw !== DFCW) $display("FAIL reset_fcw0: got %h want %h", fcw, DFCW);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, symbol_en, done} !== 3'b000)
      $display("FAIL idle_abort: got busy/en/done=%b want 000", {busy, symbol_en, done});
    else n_pass++;
  endtask

  task automatic test_nominal();
    src_q = '{8'hA5, 8'h3C};
    run_frame(2, 100, 0, 0, 0, 32'h0000_1111);
  endtask

  task automatic test_empty();
    run_frame(0, 3, 0, 0, 0, 32'h0000_2222);
    n_checks++;
    if (saw_ready !== 1'b0) $display("FAIL empty_ready: got tx_ready seen=%b want 0", saw_ready);
    else n_pass++;
  endtask

  task automatic test_underrun();
    src_q = '{8'hA5};
    run_frame(2, 4, 0, 0, 0, 32'h0000_3333);
    repeat (3) @(negedge clk);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", underrun);
    else n_pass++;
  endtask

  task automatic test_config();
    // also checks that start clears the underrun left by the previous frame
    for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom_range(0, 255)));
    run_frame(3, 2, 0, 3, 0, 32'h0A3D_70A4);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom_range(0, 255)));
    run_frame(3, 3, PL + 8 + 2, 0, 0, 32'h0000_4444);
  endtask

  task automatic test_reset_mid();
    src_q = '{8'h5A};
    run_frame(1, 2, 0, 0, PL + 2, 32'h0000_5555);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom_range(0, 255)));
      run_frame(len, 1, 0, 0, 0, $urandom);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int len, nsup;
      len  = $urandom_range(0, 5);
      nsup = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : len;
      for (int i = 0; i < nsup; i++) src_q.push_back(8'($urandom_range(0, 255)));
      run_frame(len, $urandom_range(1, 6), 0, 0, 0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_empty();
    test_underrun();
    test_config();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
